ifb_nwide: RTL

Parametrised N-wide instruction fetch buffer between the fetch stage and decode in the R10K pipeline. Each cycle it accepts up to ENQ_W fetched instructions (PC, predicted target PC, prediction bit) and presents up to DEQ_W oldest entries to decode in program order. It reports exact occupancy and free-slot counts for multi-instruction fetch flow control, and is cleared by a branch-mispredict flush.

---
 rtl/ifb_pkg.sv | 18 +
 rtl/ifb_ptr_ctr.sv | 29 ++
 rtl/ifb_nwide.sv | 108 ++++++++++
 3 files changed

// File: rtl/ifb_pkg.sv
// Shared fetch-buffer definitions: global timing/size macros and the stored entry type.
`ifndef SD
`define SD
`endif
`ifndef IFB_SIZE
`define IFB_SIZE 8
`endif

package ifb_pkg;

  typedef struct packed {
    logic [31:0] insn;
    logic [63:0] pc;
    logic [63:0] tgt_pc;
    logic        pred;
  } ifb_entry_t;

endpackage

// File: rtl/ifb_ptr_ctr.sv
// Circular-buffer pointer with wrap bit: add-by-n, synchronous clear, active-low reset.
module ifb_ptr_ctr #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned MAX_INC = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             clr_i,
  input  logic [$clog2(MAX_INC+1)-1:0]     inc_i,
  output logic [$clog2(DEPTH):0]           ptr_o
);

  localparam int unsigned PW = $clog2(DEPTH) + 1;

  logic [PW-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q + PW'(inc_i);
    if (clr_i) ptr_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ptr_q <= `SD '0;
    else        ptr_q <= `SD ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/ifb_nwide.sv
// N-wide instruction fetch buffer: ENQ_W writes and DEQ_W in-order reads per cycle,
// with exact occupancy reporting, all-or-nothing enqueue and branch-flush clear.
module ifb_nwide
  import ifb_pkg::*;
#(
  parameter int unsigned DEPTH = `IFB_SIZE,
  parameter int unsigned ENQ_W = 2,
  parameter int unsigned DEQ_W = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              flush_i,
  input  logic [$clog2(ENQ_W+1)-1:0]        enq_cnt_i,
  input  logic [ENQ_W-1:0][31:0]            enq_insn_i,
  input  logic [ENQ_W-1:0][63:0]            enq_pc_i,
  input  logic [ENQ_W-1:0][63:0]            enq_tgt_pc_i,
  input  logic [ENQ_W-1:0]                  enq_pred_i,
  input  logic [$clog2(DEQ_W+1)-1:0]        deq_cnt_i,
  output logic [DEQ_W-1:0]                  deq_vld_o,
  output logic [DEQ_W-1:0][31:0]            deq_insn_o,
  output logic [DEQ_W-1:0][63:0]            deq_pc_o,
  output logic [DEQ_W-1:0][63:0]            deq_tgt_pc_o,
  output logic [DEQ_W-1:0]                  deq_pred_o,
  output logic [$clog2(DEPTH+1)-1:0]        occ_cnt_o,
  output logic [$clog2(DEPTH+1)-1:0]        free_cnt_o,
  output logic                              empty_o,
  output logic                              full_o,
  output logic                              ovf_err_o
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned PW = IW + 1;
  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam int unsigned EW = $clog2(ENQ_W+1);
  localparam int unsigned DW = $clog2(DEQ_W+1);

  logic [PW-1:0] head, tail, occ, free, pop;
  logic [EW-1:0] tail_inc;
  logic [DW-1:0] head_inc;
  logic          accept;
  logic          ovf_q, ovf_d;
  logic [IW-1:0] widx [ENQ_W];
  logic [IW-1:0] ridx [DEQ_W];
  ifb_entry_t    rd_e [DEQ_W];
  ifb_entry_t    mem_q [DEPTH];

  ifb_ptr_ctr #(.DEPTH(DEPTH), .MAX_INC(ENQ_W)) u_tail (
    .clk(clk), .rst_n(rst_n), .clr_i(flush_i), .inc_i(tail_inc), .ptr_o(tail)
  );

  ifb_ptr_ctr #(.DEPTH(DEPTH), .MAX_INC(DEQ_W)) u_head (
    .clk(clk), .rst_n(rst_n), .clr_i(flush_i), .inc_i(head_inc), .ptr_o(head)
  );

  // Free space comes from registered pointers only; same-cycle pops do not make room.
  always_comb begin
    occ      = tail - head;
    free     = PW'(DEPTH) - occ;
    accept   = (PW'(enq_cnt_i) <= free);
    tail_inc = accept ? enq_cnt_i : '0;
    pop      = (PW'(deq_cnt_i) > occ) ? occ : PW'(deq_cnt_i);
    head_inc = DW'(pop);
    ovf_d    = ovf_q | (~flush_i & ~accept);
    for (int unsigned k = 0; k < ENQ_W; k++) widx[k] = tail[IW-1:0] + IW'(k);
    for (int unsigned k = 0; k < DEQ_W; k++) ridx[k] = head[IW-1:0] + IW'(k);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= `SD '0;
      ovf_q <= `SD 1'b0;
    end else begin
      ovf_q <= `SD ovf_d;
      if (accept && !flush_i) begin
        for (int unsigned k = 0; k < ENQ_W; k++) begin
          if (EW'(k) < enq_cnt_i)
            mem_q[widx[k]] <= `SD '{insn:   enq_insn_i[k],
                                    pc:     enq_pc_i[k],
                                    tgt_pc: enq_tgt_pc_i[k],
                                    pred:   enq_pred_i[k]};
        end
      end
    end
  end

  always_comb begin
    deq_vld_o    = '0;
    deq_insn_o   = '0;
    deq_pc_o     = '0;
    deq_tgt_pc_o = '0;
    deq_pred_o   = '0;
    for (int unsigned k = 0; k < DEQ_W; k++) begin
      deq_vld_o[k]    = (PW'(k) < occ);
      rd_e[k]         = deq_vld_o[k] ? mem_q[ridx[k]] : '0;
      deq_insn_o[k]   = rd_e[k].insn;
      deq_pc_o[k]     = rd_e[k].pc;
      deq_tgt_pc_o[k] = rd_e[k].tgt_pc;
      deq_pred_o[k]   = rd_e[k].pred;
    end
  end

  assign occ_cnt_o  = CW'(occ);
  assign free_cnt_o = CW'(free);
  assign empty_o    = (occ == '0);
  assign full_o     = (occ == PW'(DEPTH));
  assign ovf_err_o  = ovf_q;

endmodule
